// File: rtl/apb_mem_pkg.sv
// Shared types and helpers for the parametrised APB RAM slave.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package apb_mem_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic RESP_OKAY = 1'b0;
    localparam logic RESP_ERR  = 1'b1;

    // Wait-state counter covers WAIT_CYCLES up to 15.
    localparam int CNT_W = 4;

    // Number of byte-offset bits inside one data word.
    function automatic int off_width(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // Number of word-index bits; never less than one so slices stay legal.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_W word RAM with per-byte write enables and a registered read port.
// Latency: read data valid the cycle after rd_en; writes land on the enabling edge.
// Backpressure: none; always accepts a read and a write every cycle.
module apb_mem_array
    import apb_mem_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 64,
    localparam int NB     = DATA_W / 8,
    localparam int IDX_W  = idx_width(DEPTH)
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              rd_en,
    input  logic              rd_clr,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_dat,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic [NB-1:0]     wr_be
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-lane write; storage itself is deliberately not reset.
    always_ff @(posedge pclk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
                end
            end
        end
    end

    // Read register: loads on a good read, zeroes on an erroring read, holds otherwise.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rd_dat <= '0;
        end else if (rd_en) begin
            rd_dat <= mem[rd_idx];
        end else if (rd_clr) begin
            rd_dat <= '0;
        end
    end

endmodule

// File: rtl/apb_mem_slave.sv
// APB4 RAM slave with byte strobes, alignment/range error response and fixed wait states.
// Latency: pready rises in access cycle 1+WAIT_CYCLES (2-cycle transfer with no waits).
// Backpressure: pready held low for WAIT_CYCLES; psel/penable drop mid-access aborts cleanly.
// Optional: define APB_MEM_PROT_EN to reject unprivileged writes (pprot[0]=0) with pslverr.
module apb_mem_slave
    import apb_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                pclk,
    input  logic                presetn,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W/8-1:0] pstrb,
    input  logic [2:0]          pprot,
    output logic [DATA_W-1:0]   prdata,
    output logic                pready,
    output logic                pslverr
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = off_width(DATA_W);
    localparam int IDX_W = idx_width(DEPTH);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(NB - 1);
    localparam logic [ADDR_W:0]   MEM_BYTES  = (ADDR_W + 1)'(DEPTH * NB);
    localparam logic [CNT_W-1:0]  WAIT_LAST  = CNT_W'(WAIT_CYCLES);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             setup;
    logic             complete;

    logic [IDX_W-1:0] idx_q;
    logic             wr_q;
    logic             resp_q;

    logic             misaligned;
    logic             out_of_range;
    logic             prot_err;
    logic             setup_err;

    // Address decode on the live bus; only sampled at the setup edge.
    assign misaligned   = (paddr & ALIGN_MASK) != '0;
    assign out_of_range = {1'b0, paddr} >= MEM_BYTES;

`ifdef APB_MEM_PROT_EN
    assign prot_err = pwrite & ~pprot[0];
    logic unused_prot;
    assign unused_prot = ^pprot[2:1];
`else
    assign prot_err = 1'b0;
    logic unused_prot;
    assign unused_prot = ^pprot;
`endif

    assign setup_err = misaligned | out_of_range | prot_err;

    // State register, wait counter and request latches (address/direction/response).
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state  <= IDLE;
            cnt    <= '0;
            idx_q  <= '0;
            wr_q   <= 1'b0;
            resp_q <= RESP_OKAY;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (setup) begin
                idx_q  <= paddr[OFF_W +: IDX_W];
                wr_q   <= pwrite;
                resp_q <= setup_err ? RESP_ERR : RESP_OKAY;
            end
        end
    end

    // Next-state, wait counting and pready decode; any select drop in ACCESS aborts.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        setup     = 1'b0;
        complete  = 1'b0;
        pready    = 1'b0;
        case (state)
            IDLE: begin
                if (psel && !penable) begin
                    setup     = 1'b1;
                    state_nxt = ACCESS;
                    cnt_nxt   = '0;
                end
            end
            ACCESS: begin
                pready = (cnt == WAIT_LAST);
                if (!(psel && penable)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (pready) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign pslverr = pready & (resp_q == RESP_ERR);

    apb_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .pclk    (pclk),
        .presetn (presetn),
        .rd_en   (setup & ~pwrite & ~setup_err),
        .rd_clr  (setup & ~pwrite & setup_err),
        .rd_idx  (paddr[OFF_W +: IDX_W]),
        .rd_dat  (prdata),
        .wr_en   (complete & wr_q & (resp_q == RESP_OKAY)),
        .wr_idx  (idx_q),
        .wr_dat  (pwdata),
        .wr_be   (pstrb)
    );

endmodule

// File: tb/tb_apb_mem_slave.sv
// Self-checking bench for apb_mem_slave against a byte-addressed reference memory.
module tb_apb_mem_slave;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int DEPTH       = 64;
    localparam int WAIT_CYCLES = 3;
    localparam int NB          = DATA_W / 8;

    logic              pclk;
    logic              presetn;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [NB-1:0]     pstrb;
    logic [2:0]        pprot;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_bytes [DEPTH*NB];

    apb_mem_slave #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
        .pprot   (pprot),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // ---------------- reference model ----------------
    function automatic logic exp_err(input logic wr, input logic [ADDR_W-1:0] addr,
                                     input logic [2:0] prot);
        logic e;
        e = ((addr % NB) != 0) || (addr >= ADDR_W'(DEPTH * NB));
`ifdef APB_MEM_PROT_EN
        if (wr && !prot[0]) e = 1'b1;
`endif
        return e;
    endfunction

    function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] d;
        for (int b = 0; b < NB; b++) d[8*b +: 8] = ref_bytes[int'(addr) + b];
        return d;
    endfunction

    task automatic ref_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] d,
                             input logic [NB-1:0] strb);
        for (int b = 0; b < NB; b++)
            if (strb[b]) ref_bytes[int'(addr) + b] = d[8*b +: 8];
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[DATA_W-1:0];
    endfunction

    // ---------------- bus driver ----------------
    // Entered just after a rising edge; leaves just after the completion edge, so
    // consecutive calls are back-to-back with no idle cycle in between.
    task automatic xfer(input logic wr, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input logic [NB-1:0] strb,
                        input logic [2:0] prot, output logic [DATA_W-1:0] rdata,
                        output logic err, output int waits);
        bit done;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
        pwdata = wdata; pstrb = strb; pprot = prot;
        @(posedge pclk); #1;
        penable = 1'b1;
        waits = 0; rdata = '0; err = 1'b0; done = 1'b0;
        while (!done) begin
            @(negedge pclk);
            if (pready) begin
                rdata = prdata; err = pslverr; done = 1'b1;
            end else begin
                waits++;
                if (waits > WAIT_CYCLES + 4) begin
                    waits = -1; done = 1'b1;
                end
                @(posedge pclk); #1;
            end
        end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        presetn = 1'b1;
        #2 presetn = 1'b0;
        #1;
        checks++; if (pready !== 1'b0) begin errors++; $display("FAIL reset_pready: got %b want 0", pready); end
        checks++; if (pslverr !== 1'b0) begin errors++; $display("FAIL reset_pslverr: got %b want 0", pslverr); end
        checks++; if (prdata !== '0) begin errors++; $display("FAIL reset_prdata: got %h want 0", prdata); end
        repeat (3) @(posedge pclk);
        #1 presetn = 1'b1;
        @(negedge pclk);
        checks++; if (pready !== 1'b0) begin errors++; $display("FAIL idle_pready: got %b want 0", pready); end
        @(posedge pclk); #1;
    endtask

    task automatic test_init();
        logic [DATA_W-1:0] rd, d;
        logic er;
        int w;
        for (int i = 0; i < DEPTH; i++) begin
            d = rnd_data();
            xfer(1'b1, ADDR_W'(i * NB), d, '1, 3'b001, rd, er, w);
            ref_write(ADDR_W'(i * NB), d, '1);
            checks++; if (er !== 1'b0) begin errors++; $display("FAIL init_err[%0d]: got %b want 0", i, er); end
        end
    endtask

    task automatic test_full_word();
        logic [DATA_W-1:0] rd;
        logic er;
        int w;
        xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b001, rd, er, w);
        ref_write(32'h10, 32'hDEADBEEF, 4'hF);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr10_err: got %b want 0", er); end
        checks++; if (w !== WAIT_CYCLES) begin errors++; $display("FAIL wr10_latency: got %0d want %0d", w, WAIT_CYCLES); end
        xfer(1'b0, 32'h10, '0, '0, 3'b001, rd, er, w);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd10_data: got %h want deadbeef", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd10_err: got %b want 0", er); end
        checks++; if (w !== WAIT_CYCLES) begin errors++; $display("FAIL rd10_latency: got %0d want %0d", w, WAIT_CYCLES); end
    endtask

    task automatic test_strobe();
        logic [DATA_W-1:0] rd;
        logic er;
        int w;
        xfer(1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 3'b001, rd, er, w);
        ref_write(32'h20, 32'hFFFFFFFF, 4'hF);
        xfer(1'b1, 32'h20, 32'h00000000, 4'b0101, 3'b001, rd, er, w);
        ref_write(32'h20, 32'h00000000, 4'b0101);
        xfer(1'b0, 32'h20, '0, 4'hF, 3'b001, rd, er, w);
        checks++; if (rd !== 32'hFF00FF00) begin errors++; $display("FAIL strobe_data: got %h want ff00ff00", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL strobe_rd_err: got %b want 0", er); end
    endtask

    task automatic test_errors();
        logic [DATA_W-1:0] rd;
        logic er;
        int w;
        xfer(1'b0, 32'h100, '0, '0, 3'b001, rd, er, w);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_rd_err: got %b want 1", er); end
        checks++; if (rd !== '0) begin errors++; $display("FAIL oor_rd_data: got %h want 0", rd); end
        checks++; if (w !== WAIT_CYCLES) begin errors++; $display("FAIL oor_rd_latency: got %0d want %0d", w, WAIT_CYCLES); end
        xfer(1'b1, 32'h102, 32'h5A5A5A5A, 4'hF, 3'b001, rd, er, w);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL misal_wr_err: got %b want 1", er); end
        xfer(1'b1, 32'h104, 32'hA5A5A5A5, 4'hF, 3'b001, rd, er, w);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_wr_err: got %b want 1", er); end
        xfer(1'b0, 32'h0, '0, '0, 3'b001, rd, er, w);
        checks++; if (rd !== ref_read(32'h0)) begin errors++; $display("FAIL misal_no_commit: got %h want %h", rd, ref_read(32'h0)); end
        xfer(1'b0, 32'h4, '0, '0, 3'b001, rd, er, w);
        checks++; if (rd !== ref_read(32'h4)) begin errors++; $display("FAIL oor_no_commit: got %h want %h", rd, ref_read(32'h4)); end
        xfer(1'b0, 32'h13, '0, '0, 3'b001, rd, er, w);
        checks++; if (er !== 1'b1 || rd !== '0) begin errors++; $display("FAIL misal_rd: got err=%b data=%h want err=1 data=0", er, rd); end
    endtask

    task automatic test_abort();
        logic [DATA_W-1:0] rd;
        logic er;
        int w;
        // Variant 1: penable never raised in the access cycle.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h11223344; pstrb = '1; pprot = 3'b001;
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        psel = 1'b0;
        @(negedge pclk);
        checks++; if (pready !== 1'b0) begin errors++; $display("FAIL abort1_pready: got %b want 0", pready); end
        @(posedge pclk); #1;
        // Variant 2: penable raised, then the whole select dropped before pready.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h55667788;
        @(posedge pclk); #1 penable = 1'b1;
        @(negedge pclk);
        checks++; if (pready !== 1'b0) begin errors++; $display("FAIL abort2_early_pready: got %b want 0", pready); end
        @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        checks++; if (pready !== 1'b0 || pslverr !== 1'b0) begin errors++; $display("FAIL abort2_idle: got pready=%b pslverr=%b want 0 0", pready, pslverr); end
        @(posedge pclk); #1;
        xfer(1'b0, 32'h08, '0, '0, 3'b001, rd, er, w);
        checks++; if (rd !== ref_read(32'h08)) begin errors++; $display("FAIL abort_no_commit: got %h want %h", rd, ref_read(32'h08)); end
        checks++; if (w !== WAIT_CYCLES) begin errors++; $display("FAIL abort_recover_latency: got %0d want %0d", w, WAIT_CYCLES); end
    endtask

    task automatic test_midaccess_change();
        logic [DATA_W-1:0] rd;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h20; pstrb = '1; pprot = 3'b001;
        @(posedge pclk); #1;
        penable = 1'b1; pwrite = 1'b1; paddr = 32'h30; pwdata = 32'hCAFEF00D;
        repeat (WAIT_CYCLES) @(posedge pclk);
        @(negedge pclk);
        rd = prdata;
        checks++; if (pready !== 1'b1) begin errors++; $display("FAIL chg_pready: got %b want 1", pready); end
        checks++; if (rd !== ref_read(32'h20)) begin errors++; $display("FAIL chg_latched_read: got %h want %h", rd, ref_read(32'h20)); end
        @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
        begin
            logic er; int w;
            xfer(1'b0, 32'h30, '0, '0, 3'b001, rd, er, w);
        end
        checks++; if (rd !== ref_read(32'h30)) begin errors++; $display("FAIL chg_no_write: got %h want %h", rd, ref_read(32'h30)); end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] rd, d0, d1;
        logic er;
        int w;
        d0 = rnd_data(); d1 = rnd_data();
        xfer(1'b1, 32'h40, d0, '1, 3'b001, rd, er, w);
        ref_write(32'h40, d0, '1);
        xfer(1'b0, 32'h40, '0, '0, 3'b001, rd, er, w);
        checks++; if (rd !== d0 || w !== WAIT_CYCLES) begin errors++; $display("FAIL b2b_rd0: got %h lat %0d want %h lat %0d", rd, w, d0, WAIT_CYCLES); end
        xfer(1'b1, 32'h44, d1, '1, 3'b001, rd, er, w);
        ref_write(32'h44, d1, '1);
        checks++; if (w !== WAIT_CYCLES) begin errors++; $display("FAIL b2b_wr1_latency: got %0d want %0d", w, WAIT_CYCLES); end
        xfer(1'b0, 32'h44, '0, 4'hA, 3'b001, rd, er, w);
        checks++; if (rd !== d1 || er !== 1'b0) begin errors++; $display("FAIL b2b_rd1: got %h err %b want %h err 0", rd, er, d1); end
    endtask

    task automatic test_reset_mid();
        logic [DATA_W-1:0] rd;
        logic er;
        int w;
        xfer(1'b0, 32'h10, '0, '0, 3'b001, rd, er, w);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h12345678; pstrb = '1; pprot = 3'b001;
        @(posedge pclk); #1 penable = 1'b1;
        repeat (WAIT_CYCLES) @(posedge pclk);
        @(negedge pclk);
        checks++; if (pready !== 1'b1) begin errors++; $display("FAIL rstmid_pre_pready: got %b want 1", pready); end
        #2 presetn = 1'b0;
        #1;
        checks++; if (pready !== 1'b0 || pslverr !== 1'b0) begin errors++; $display("FAIL rstmid_resp: got pready=%b pslverr=%b want 0 0", pready, pslverr); end
        checks++; if (prdata !== '0) begin errors++; $display("FAIL rstmid_prdata: got %h want 0", prdata); end
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1 presetn = 1'b1;
        @(posedge pclk); #1;
        xfer(1'b0, 32'h10, '0, '0, 3'b001, rd, er, w);
        checks++; if (rd !== ref_read(32'h10)) begin errors++; $display("FAIL rstmid_no_commit: got %h want %h", rd, ref_read(32'h10)); end
    endtask

    task automatic test_prot();
        logic [DATA_W-1:0] rd;
        logic er;
        int w;
        xfer(1'b1, 32'h48, 32'h0BADC0DE, '1, 3'b000, rd, er, w);
`ifdef APB_MEM_PROT_EN
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL prot_unpriv_err: got %b want 1", er); end
`else
        ref_write(32'h48, 32'h0BADC0DE, '1);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL prot_ignored_err: got %b want 0", er); end
`endif
        xfer(1'b0, 32'h48, '0, '0, 3'b000, rd, er, w);
        checks++; if (rd !== ref_read(32'h48) || er !== 1'b0) begin errors++; $display("FAIL prot_rd0: got %h err %b want %h err 0", rd, er, ref_read(32'h48)); end
        xfer(1'b1, 32'h48, 32'h600DF00D, '1, 3'b001, rd, er, w);
        ref_write(32'h48, 32'h600DF00D, '1);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL prot_priv_err: got %b want 0", er); end
        xfer(1'b0, 32'h48, '0, '0, 3'b001, rd, er, w);
        checks++; if (rd !== 32'h600DF00D) begin errors++; $display("FAIL prot_priv_commit: got %h want 600df00d", rd); end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] rd, d, exp_d;
        logic [ADDR_W-1:0] a;
        logic [NB-1:0] s;
        logic [2:0] p;
        logic wr, er, e_err;
        int w, sel;
        for (int i = 0; i < 300; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel <= 6)      a = ADDR_W'($urandom_range(0, DEPTH - 1) * NB);
            else if (sel == 7) a = ADDR_W'($urandom_range(0, DEPTH - 1) * NB + $urandom_range(1, NB - 1));
            else if (sel == 8) a = ADDR_W'(DEPTH * NB + $urandom_range(0, 255) * NB);
            else               a = $urandom();
            wr = 1'($urandom_range(0, 1));
            d  = rnd_data();
            s  = NB'($urandom());
            p  = 3'($urandom());
            e_err = exp_err(wr, a, p);
            exp_d = (wr || e_err) ? '0 : ref_read(a);
            xfer(wr, a, d, s, p, rd, er, w);
            if (wr && !e_err) ref_write(a, d, s);
            checks++; if (er !== e_err) begin errors++; $display("FAIL rnd_err[%0d] a=%h wr=%b: got %b want %b", i, a, wr, er, e_err); end
            checks++; if (w !== WAIT_CYCLES) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", i, w, WAIT_CYCLES); end
            if (!wr) begin
                checks++; if (rd !== exp_d) begin errors++; $display("FAIL rnd_rdata[%0d] a=%h: got %h want %h", i, a, rd, exp_d); end
            end
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end
    endtask

    initial begin
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
        pwdata = '0; pstrb = '0; pprot = 3'b001; presetn = 1'b1;
        test_reset();
        test_init();
        test_full_word();
        test_strobe();
        test_errors();
        test_abort();
        test_midaccess_change();
        test_back_to_back();
        test_reset_mid();
        test_prot();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
